// File: rtl/store_packer_if.sv
// store_packer_if: request side from execute and write side toward data memory
interface store_packer_if #(parameter int CNT_W = 2);
    logic             req_valid;
    logic             req_ready;
    logic [31:0]      req_addr;
    logic [31:0]      req_data;
    logic [1:0]       req_size;
    logic             mem_valid;
    logic             mem_ready;
    logic [31:0]      mem_addr;
    logic [31:0]      mem_wdata;
    logic [3:0]       mem_be;
    logic             misalign_err;
    logic [31:0]      err_addr;
    logic [CNT_W-1:0] count;
    modport master (
        output req_valid, req_addr, req_data, req_size, mem_ready,
        input  req_ready, mem_valid, mem_addr, mem_wdata, mem_be, misalign_err, err_addr, count
    );
    modport slave (
        input  req_valid, req_addr, req_data, req_size, mem_ready,
        output req_ready, mem_valid, mem_addr, mem_wdata, mem_be, misalign_err, err_addr, count
    );
endinterface

// File: rtl/store_packer.sv
// store_packer: lane-aligns sb/sh/sw stores, drops misaligned/illegal ones, queues writes toward memory
module store_packer #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 2
) (
    input logic          clk,
    input logic          rst_n,
    store_packer_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    logic [29:0]      addr_m [DEPTH];
    logic [31:0]      data_m [DEPTH];
    logic [3:0]       be_m   [DEPTH];
    logic [PW-1:0]    wp, rp;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      wdata;
    logic [3:0]       be;
    logic             bad, accept, push, pop;
    always_comb begin
        wdata = bus.req_size == 2'b00 ? {4{bus.req_data[7:0]}} :
                bus.req_size == 2'b01 ? {2{bus.req_data[15:0]}} : bus.req_data;
        be    = bus.req_size == 2'b00 ? 4'b0001 << bus.req_addr[1:0] :
                bus.req_size == 2'b01 ? (bus.req_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        bad   = bus.req_size == 2'b11 ||
                (bus.req_size == 2'b01 && bus.req_addr[0]) ||
                (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00);
    end
    // ready depends only on occupancy so a pop never combinationally opens the request side
    assign bus.req_ready = cnt != CNT_W'(DEPTH);
    assign bus.mem_valid = cnt != '0;
    assign accept        = bus.req_valid && bus.req_ready;
    assign push          = accept && !bad;
    assign pop           = bus.mem_valid && bus.mem_ready;
    assign bus.mem_addr  = bus.mem_valid ? {addr_m[rp], 2'b00} : '0;
    assign bus.mem_wdata = bus.mem_valid ? data_m[rp] : '0;
    assign bus.mem_be    = bus.mem_valid ? be_m[rp] : '0;
    assign bus.count     = cnt;
    always_ff @(posedge clk) begin
        if (push) begin
            addr_m[wp] <= bus.req_addr[31:2];
            data_m[wp] <= wdata;
            be_m[wp]   <= be;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp               <= '0;
            rp               <= '0;
            cnt              <= '0;
            bus.misalign_err <= 1'b0;
            bus.err_addr     <= '0;
        end else begin
            if (push) wp <= wp + 1'b1;
            if (pop) rp <= rp + 1'b1;
            cnt              <= cnt + CNT_W'(push) - CNT_W'(pop);
            bus.misalign_err <= accept && bad;
            if (accept && bad) bus.err_addr <= bus.req_addr;
        end
    end
endmodule

// File: tb/tb_store_packer.sv
// tb_store_packer: directed scenario tasks with hand-computed expectations for store_packer
module tb_store_packer;
    logic clk, rst_n;
    int checks = 0, errors = 0;
    store_packer_if #(.CNT_W(2)) bus ();
    store_packer #(.DEPTH(2), .CNT_W(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic req(input logic v, input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
        bus.req_valid = v;
        bus.req_addr  = a;
        bus.req_data  = d;
        bus.req_size  = s;
    endtask
    task automatic test_reset;
        rst_n = 0;
        req(0, 0, 0, 0);
        bus.mem_ready = 0;
        tick;
        tick;
        rst_n = 1;
        tick;
        checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", bus.req_ready); end
        checks++; if (bus.mem_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", bus.mem_valid); end
        checks++; if (bus.count !== 2'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", bus.count); end
        checks++; if ({bus.mem_addr, bus.mem_wdata, bus.mem_be} !== 68'h0) begin errors++; $display("FAIL reset_mem got %h %h %b exp 0", bus.mem_addr, bus.mem_wdata, bus.mem_be); end
        checks++; if ({bus.misalign_err, bus.err_addr} !== 33'h0) begin errors++; $display("FAIL reset_err got %b %h exp 0", bus.misalign_err, bus.err_addr); end
    endtask
    task automatic test_byte;
        req(1, 32'h1003, 32'hAABBCC5A, 2'b00);
        tick;
        req(0, 0, 0, 0);
        checks++; if (bus.mem_valid !== 1'b1) begin errors++; $display("FAIL sb_valid got %b exp 1", bus.mem_valid); end
        checks++; if (bus.mem_addr !== 32'h1000) begin errors++; $display("FAIL sb_addr got %h exp 00001000", bus.mem_addr); end
        checks++; if (bus.mem_wdata !== 32'h5A5A5A5A) begin errors++; $display("FAIL sb_wdata got %h exp 5a5a5a5a", bus.mem_wdata); end
        checks++; if (bus.mem_be !== 4'b1000) begin errors++; $display("FAIL sb_be got %b exp 1000", bus.mem_be); end
        checks++; if (bus.misalign_err !== 1'b0) begin errors++; $display("FAIL sb_err got %b exp 0", bus.misalign_err); end
        bus.mem_ready = 1;
        tick;
        bus.mem_ready = 0;
        checks++; if (bus.count !== 2'd0) begin errors++; $display("FAIL sb_drain got %0d exp 0", bus.count); end
        checks++; if (bus.mem_wdata !== 32'h0) begin errors++; $display("FAIL sb_idle_wdata got %h exp 0", bus.mem_wdata); end
    endtask
    task automatic test_backpressure;
        req(1, 32'h2002, 32'h0000BEEF, 2'b01);
        tick;
        req(1, 32'h2004, 32'h12345678, 2'b10);
        tick;
        req(0, 0, 0, 0);
        checks++; if (bus.count !== 2'd2) begin errors++; $display("FAIL bp_count got %0d exp 2", bus.count); end
        checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL bp_ready got %b exp 0", bus.req_ready); end
        for (int i = 0; i < 3; i++) begin
            tick;
            checks++; if ({bus.mem_addr, bus.mem_wdata, bus.mem_be} !== {32'h2000, 32'hBEEFBEEF, 4'b1100}) begin errors++; $display("FAIL bp_hold%0d got %h %h %b exp 00002000 beefbeef 1100", i, bus.mem_addr, bus.mem_wdata, bus.mem_be); end
        end
        bus.mem_ready = 1;
        tick;
        checks++; if ({bus.mem_addr, bus.mem_wdata, bus.mem_be} !== {32'h2004, 32'h12345678, 4'b1111}) begin errors++; $display("FAIL bp_second got %h %h %b exp 00002004 12345678 1111", bus.mem_addr, bus.mem_wdata, bus.mem_be); end
        checks++; if (bus.count !== 2'd1) begin errors++; $display("FAIL bp_count1 got %0d exp 1", bus.count); end
        tick;
        bus.mem_ready = 0;
        checks++; if (bus.count !== 2'd0) begin errors++; $display("FAIL bp_drain got %0d exp 0", bus.count); end
    endtask
    task automatic test_errors;
        logic [31:0] ea [3] = '{32'h3001, 32'h3003, 32'h3000};
        logic [1:0]  es [3] = '{2'b10, 2'b01, 2'b11};
        for (int i = 0; i < 3; i++) begin
            req(1, ea[i], 32'hFFFF0000, es[i]);
            tick;
            req(0, 0, 0, 0);
            checks++; if (bus.misalign_err !== 1'b1) begin errors++; $display("FAIL err%0d_pulse got %b exp 1", i, bus.misalign_err); end
            checks++; if (bus.err_addr !== ea[i]) begin errors++; $display("FAIL err%0d_addr got %h exp %h", i, bus.err_addr, ea[i]); end
            checks++; if (bus.count !== 2'd0 || bus.mem_valid !== 1'b0) begin errors++; $display("FAIL err%0d_enq got %0d/%b exp 0/0", i, bus.count, bus.mem_valid); end
            tick;
            checks++; if (bus.misalign_err !== 1'b0) begin errors++; $display("FAIL err%0d_clear got %b exp 0", i, bus.misalign_err); end
            checks++; if (bus.err_addr !== ea[i]) begin errors++; $display("FAIL err%0d_hold got %h exp %h", i, bus.err_addr, ea[i]); end
        end
        req(1, 32'h4002, 0, 2'b10);
        tick;
        req(1, 32'h4001, 0, 2'b01);
        checks++; if (bus.misalign_err !== 1'b1 || bus.err_addr !== 32'h4002) begin errors++; $display("FAIL b2b_first got %b %h exp 1 00004002", bus.misalign_err, bus.err_addr); end
        tick;
        req(0, 0, 0, 0);
        checks++; if (bus.misalign_err !== 1'b1 || bus.err_addr !== 32'h4001) begin errors++; $display("FAIL b2b_second got %b %h exp 1 00004001", bus.misalign_err, bus.err_addr); end
        tick;
        checks++; if (bus.misalign_err !== 1'b0) begin errors++; $display("FAIL b2b_clear got %b exp 0", bus.misalign_err); end
    endtask
    task automatic test_full_wrap;
        int sent = 0, popped = 0, cm = 0;
        logic push, pop;
        for (int c = 0; c < 40 && popped < 7; c++) begin
            bus.mem_ready = c < 2 ? 1'b0 : c % 2 == 0;
            req(sent < 7, 32'h5000 + 4 * sent, 32'hC0DE0000 + sent, 2'b10);
            checks++; if (bus.count !== 2'(cm) || bus.req_ready !== (cm != 2) || bus.mem_valid !== (cm != 0)) begin errors++; $display("FAIL wrap_state c%0d got %0d/%b/%b exp %0d", c, bus.count, bus.req_ready, bus.mem_valid, cm); end
            push = sent < 7 && cm != 2;
            pop  = bus.mem_ready && cm != 0;
            if (pop) begin
                checks++; if (bus.mem_wdata !== 32'hC0DE0000 + popped || bus.mem_addr !== 32'h5000 + 4 * popped) begin errors++; $display("FAIL wrap_data%0d got %h %h", popped, bus.mem_addr, bus.mem_wdata); end
            end
            tick;
            sent += int'(push);
            popped += int'(pop);
            cm = cm + int'(push) - int'(pop);
        end
        req(0, 0, 0, 0);
        bus.mem_ready = 0;
        checks++; if (popped != 7) begin errors++; $display("FAIL wrap_timeout got %0d exp 7", popped); end
    endtask
    task automatic test_stream;
        int sent = 0, popped = 0, cm = 0;
        logic push, pop;
        logic [7:0] b;
        for (int c = 0; c < 40 && popped < 8; c++) begin
            bus.mem_ready = c % 2 == 0;
            req(sent < 8, sent, {24'hABCDEF, 8'(8'h11 * sent)}, 2'b00);
            push = sent < 8 && cm != 2;
            pop  = bus.mem_ready && cm != 0;
            if (pop) begin
                b = 8'(8'h11 * popped);
                checks++; if ({bus.mem_addr, bus.mem_wdata, bus.mem_be} !== {32'(popped & ~3), {4{b}}, 4'(4'b0001 << (popped % 4))}) begin errors++; $display("FAIL stream%0d got %h %h %b", popped, bus.mem_addr, bus.mem_wdata, bus.mem_be); end
            end
            tick;
            sent += int'(push);
            popped += int'(pop);
            cm = cm + int'(push) - int'(pop);
        end
        req(0, 0, 0, 0);
        bus.mem_ready = 0;
        checks++; if (popped != 8) begin errors++; $display("FAIL stream_timeout got %0d exp 8", popped); end
    endtask
    task automatic test_async_reset;
        req(1, 32'h6000, 32'h11112222, 2'b10);
        tick;
        req(1, 32'h6004, 32'h33334444, 2'b10);
        tick;
        req(0, 0, 0, 0);
        checks++; if (bus.count !== 2'd2) begin errors++; $display("FAIL ar_fill got %0d exp 2", bus.count); end
        #2 rst_n = 0;
        #1;
        checks++; if (bus.count !== 2'd0 || bus.mem_valid !== 1'b0) begin errors++; $display("FAIL ar_immediate got %0d/%b exp 0/0", bus.count, bus.mem_valid); end
        checks++; if ({bus.mem_addr, bus.mem_wdata, bus.mem_be, bus.err_addr} !== 100'h0) begin errors++; $display("FAIL ar_outputs got %h %h %b %h exp 0", bus.mem_addr, bus.mem_wdata, bus.mem_be, bus.err_addr); end
        #1 rst_n = 1;
        tick;
        checks++; if (bus.mem_valid !== 1'b0 || bus.count !== 2'd0 || bus.req_ready !== 1'b1) begin errors++; $display("FAIL ar_release got %b/%0d/%b exp 0/0/1", bus.mem_valid, bus.count, bus.req_ready); end
    endtask
    initial begin
        test_reset;
        test_byte;
        test_backpressure;
        test_errors;
        test_full_wrap;
        test_stream;
        test_async_reset;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/store_packer.md
Name: store_packer

Overview:
- Store-side data path between the execute stage and data memory; the narrowing counterpart of the immediate/load extension logic.
- Accepts sb/sh/sw requests with a byte address and 32-bit register data.
- Places the data on the correct byte lanes and generates byte enables.
- Queues packed writes in a small FIFO with a valid/ready handshake toward memory, and flags misaligned or illegal requests.

Parameters:
- DEPTH, 2, FIFO entries; power of two, minimum 2.
- CNT_W, 2, width of `count`; must hold values 0..DEPTH.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  store request present
- req_ready  out  1  store_packer can accept a request
- req_addr  in  32  byte address
- req_data  in  32  register rt value
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal
- mem_valid  out  1  packed write available at FIFO head
- mem_ready  in  1  memory accepts head write
- mem_addr  out  32  word address, {req_addr[31:2],2'b00}
- mem_wdata  out  32  lane-aligned write data
- mem_be  out  4  byte enables, bit i = byte lane i (bits 8i+7:8i)
- misalign_err  out  1  one-cycle pulse: the request accepted last cycle was dropped
- err_addr  out  32  req_addr of the most recent dropped request
- count  out  CNT_W  FIFO occupancy

Behaviour:
- Reset (rst_n low, asynchronous): FIFO empty, count=0, mem_valid=0, mem_addr=0, mem_wdata=0, mem_be=0, misalign_err=0, err_addr=0. req_ready=1 immediately after release.
- Reset mid-operation: all queued writes are discarded; nothing is replayed.
- Request accept: accept = req_valid & req_ready.
- req_ready = (count != DEPTH). It is registered-state only and has no combinational path from mem_ready.
- Packing for byte (size 00):
  - wdata = {4{req_data[7:0]}}
  - be = 4'b0001 << req_addr[1:0]
  - never misaligned
- Packing for half (size 01):
  - wdata = {2{req_data[15:0]}}
  - be = req_addr[1] ? 4'b1100 : 4'b0011
  - misaligned if req_addr[0]=1
- Packing for word (size 10):
  - wdata = req_data
  - be = 4'b1111
  - misaligned if req_addr[1:0]!=0
- Illegal size (11): always treated as an error.
- Error handling:
  - An erroneous accepted request completes its handshake but is not enqueued.
  - misalign_err is high for exactly the cycle after acceptance.
  - err_addr is loaded with req_addr on the same edge and holds until the next error.
  - Back-to-back errors give misalign_err high on consecutive cycles.
- Head-output timing:
  - A good request accepted at edge N into an empty FIFO gives mem_valid=1 from edge N onward (one-cycle latency).
  - There is no combinational bypass from req_* to mem_*.
- Memory handshake:
  - pop = mem_valid & mem_ready.
  - mem_addr, mem_wdata and mem_be must stay stable while mem_valid=1 and mem_ready=0.
- Idle outputs: when the FIFO is empty, mem_valid=0 and mem_addr, mem_wdata, mem_be are driven 0.
- Simultaneous push and pop:
  - The count is unchanged and entry order is preserved.
  - When full, a pop frees space only for the next cycle because req_ready is state-based.
- Pointers: read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH. count is updated by +1, -1 or 0 per cycle.
- Ordering: writes reach memory in strict acceptance order; dropped requests occupy no slot.

Test Plan:
- Reset, then sb addr 0x1003 data 0xAABBCC5A -> next cycle mem_valid=1, mem_addr 0x1000, mem_wdata 0x5A5A5A5A, mem_be 1000; mem_ready=1 -> count returns to 0.
- sh addr 0x2002 data 0x0000BEEF, then sw addr 0x2004 data 0x12345678, with mem_ready=0 -> count=2 and req_ready=0; hold 3 cycles and check head stable (wdata 0xBEEFBEEF, be 1100); release -> 0x12345678/1111 follows.
- sw addr 0x3001 -> no enqueue, misalign_err high one cycle, err_addr 0x00003001, count unchanged. Repeat with sh addr 0x3003 and with size 11 -> same behaviour.
- FIFO full with mem_ready=1 and req_valid held -> pop in cycle k, accept in cycle k+1, count alternates 2→1→2, data order preserved across pointer wrap (≥5 writes).
- Continuous stream of 8 sb to addrs 0..7, mem_ready toggling 1/0 -> all 8 writes appear in order with be cycling 0001, 0010, 0100, 1000.
- rst_n asserted asynchronously mid-cycle with count=2 -> outputs zero immediately; after release mem_valid=0, count=0, req_ready=1.
